// File: rtl/vjtag_pkg.sv
// Shared types for the virtual-JTAG host sequencer and its targets: IR encodings,
// host FSM states and the bit-counter width helper.
package vjtag_pkg;

    typedef enum logic [1:0] {
        IR_BYPASS = 2'b00,
        IR_WRITE  = 2'b01,
        IR_READ   = 2'b10
    } jtag_ir_state_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        IR_SET  = 3'd1,
        CAPTURE = 3'd2,
        SHIFT   = 3'd3,
        UPDATE  = 3'd4,
        RESP    = 3'd5
    } host_state_t;

    localparam int unsigned DW_DEF = 8;
    localparam int unsigned CNT_W  = $clog2(DW_DEF);

    // Counter width for a DW-bit register; DW >= 2 keeps this at least 1.
    function automatic int unsigned cnt_width(input int unsigned dw);
        return $clog2(dw);
    endfunction

endpackage

// File: rtl/vjtag_host_seq_if.sv
// Command/response handshake and virtual-JTAG strobe bundle between the host
// sequencer (master) and whatever sits on the other side (slave).
interface vjtag_host_seq_if #(
    parameter int unsigned DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [1:0]    ir_in;
    logic          v_cdr;
    logic          v_sdr;
    logic          udr;
    logic          tdi;
    logic          tdo;

    modport master (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready, tdo,
        output cmd_ready, rsp_valid, rsp_data, rsp_err,
        output ir_in, v_cdr, v_sdr, udr, tdi
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_data, rsp_ready, tdo,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err,
        input  ir_in, v_cdr, v_sdr, udr, tdi
    );
endinterface

// File: rtl/vjtag_host_seq.sv
// Virtual-JTAG initiator: turns one parallel command into IR-select, Capture-DR,
// DW x Shift-DR, Update-DR, and returns the DW bits sampled from tdo.
module vjtag_host_seq
    import vjtag_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic tck,
    input  logic aclr,
    vjtag_host_seq_if.master bus
);

    localparam int unsigned CW = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [DW-1:0] DW_ZERO  = {DW{1'b0}};

    host_state_t    state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  tx_sr_q, tx_sr_d;
    logic [DW-1:0]  rx_sr_q, rx_sr_d;
    logic           op_err_q, op_err_d;
    logic           cmd_ready_q, cmd_ready_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]  rsp_data_q, rsp_data_d;
    logic           rsp_err_q, rsp_err_d;
    jtag_ir_state_t ir_in_q, ir_in_d;
    logic           v_cdr_q, v_cdr_d;
    logic           v_sdr_q, v_sdr_d;
    logic           udr_q, udr_d;
    logic           tdi_q, tdi_d;

    // Next-state and next-output logic; outputs are computed one cycle ahead so
    // every port comes straight from a flop.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        op_err_d    = op_err_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        ir_in_d     = ir_in_q;
        v_cdr_d     = 1'b0;
        v_sdr_d     = 1'b0;
        udr_d       = 1'b0;
        tdi_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    state_d     = IR_SET;
                    cmd_ready_d = 1'b0;
                    tx_sr_d     = bus.cmd_data;
                    rx_sr_d     = DW_ZERO;
                    cnt_d       = CNT_ZERO;
                    op_err_d    = (bus.cmd_op == 2'b11);
                    // The illegal op still runs a full sequence, but through BYPASS.
                    if (bus.cmd_op == 2'b11) begin
                        ir_in_d = IR_BYPASS;
                    end else begin
                        ir_in_d = jtag_ir_state_t'(bus.cmd_op);
                    end
                end else begin
                    cmd_ready_d = 1'b1;
                end
            end
            IR_SET: begin
                state_d = CAPTURE;
                v_cdr_d = 1'b1;
            end
            CAPTURE: begin
                state_d = SHIFT;
                v_sdr_d = 1'b1;
                tdi_d   = tx_sr_q[0];
                tx_sr_d = {1'b0, tx_sr_q[DW-1:1]};
            end
            SHIFT: begin
                rx_sr_d = {bus.tdo, rx_sr_q[DW-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = UPDATE;
                    cnt_d   = CNT_ZERO;
                    udr_d   = 1'b1;
                end else begin
                    cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    v_sdr_d = 1'b1;
                    tdi_d   = tx_sr_q[0];
                    tx_sr_d = {1'b0, tx_sr_q[DW-1:1]};
                end
            end
            UPDATE: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
                rsp_data_d  = rx_sr_q;
                rsp_err_d   = op_err_q;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge tck) begin
        if (aclr) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_ZERO;
            tx_sr_q     <= DW_ZERO;
            rx_sr_q     <= DW_ZERO;
            op_err_q    <= 1'b0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= DW_ZERO;
            rsp_err_q   <= 1'b0;
            ir_in_q     <= IR_BYPASS;
            v_cdr_q     <= 1'b0;
            v_sdr_q     <= 1'b0;
            udr_q       <= 1'b0;
            tdi_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tx_sr_q     <= tx_sr_d;
            rx_sr_q     <= rx_sr_d;
            op_err_q    <= op_err_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            ir_in_q     <= ir_in_d;
            v_cdr_q     <= v_cdr_d;
            v_sdr_q     <= v_sdr_d;
            udr_q       <= udr_d;
            tdi_q       <= tdi_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.ir_in     = ir_in_q;
    assign bus.v_cdr     = v_cdr_q;
    assign bus.v_sdr     = v_sdr_q;
    assign bus.udr       = udr_q;
    assign bus.tdi       = tdi_q;

endmodule

// File: tb/tb_vjtag_host_seq.sv
// Directed bench for vjtag_host_seq driving a small behavioural vjtag target.
module tb_vjtag_host_seq;

    logic tck = 1'b0;
    logic aclr;
    int   checks = 0;
    int   errors = 0;

    vjtag_host_seq_if #(.DW(8)) bus ();

    vjtag_host_seq #(.DW(8)) dut (
        .tck  (tck),
        .aclr (aclr),
        .bus  (bus.master)
    );

    always #5 tck = ~tck;

    // Behavioural target: IR 01 = DR1 (write reg), 10 = read capture, 00 = bypass.
    logic [7:0] t_sr;
    logic [7:0] t_out = 8'h00;
    logic [7:0] t_in  = 8'h00;
    logic       t_byp = 1'b0;

    always @(posedge tck) begin
        if (bus.v_cdr) begin
            if (bus.ir_in == 2'b01) t_sr <= t_out;
            else if (bus.ir_in == 2'b10) t_sr <= t_in;
            t_byp <= 1'b0;
        end else if (bus.v_sdr) begin
            t_sr  <= {bus.tdi, t_sr[7:1]};
            t_byp <= bus.tdi;
        end else if (bus.udr && bus.ir_in == 2'b01) begin
            t_out <= t_sr;
        end
    end

    assign bus.tdo = (bus.ir_in == 2'b00) ? t_byp : t_sr[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge tck);
        #1;
    endtask

    // Present a command and clock the accepting edge; optionally drop cmd_valid.
    task automatic accept(input logic [1:0] op, input logic [7:0] data, input logic drop);
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        bus.cmd_valid = 1'b1;
        chk("pre_accept_ready", 32'(bus.cmd_ready), 32'h1);
        step();
        if (drop) bus.cmd_valid = 1'b0;
    endtask

    // Runs from cycle T+1 up to the first RESP cycle T+12, checking every cycle.
    task automatic run_body(input logic [1:0] exp_ir, input logic [7:0] tx,
                            input logic [7:0] exp_rsp, input logic exp_err);
        int nsdr;
        nsdr = 0;
        chk("ir_in_t1", 32'(bus.ir_in), 32'(exp_ir));
        chk("ready_t1", 32'(bus.cmd_ready), 32'h0);
        chk("strobes_t1", 32'({bus.v_cdr, bus.v_sdr, bus.udr}), 32'h0);
        step();
        chk("v_cdr_t2", 32'({bus.v_cdr, bus.v_sdr, bus.udr, bus.tdi}), 32'b1000);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("shift_strobes", 32'({bus.v_cdr, bus.v_sdr, bus.udr}), 32'b010);
            chk("tdi_bit", 32'(bus.tdi), 32'(tx[k]));
            if (bus.v_sdr) nsdr++;
        end
        chk("sdr_count", 32'(nsdr), 32'd8);
        step();
        chk("udr_t11", 32'({bus.v_cdr, bus.v_sdr, bus.udr, bus.tdi, bus.rsp_valid}), 32'b00100);
        step();
        chk("rsp_valid_t12", 32'(bus.rsp_valid), 32'h1);
        chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp));
        chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("strobes_resp", 32'({bus.v_cdr, bus.v_sdr, bus.udr}), 32'h0);
        chk("ir_hold_resp", 32'(bus.ir_in), 32'(exp_ir));
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("hs_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        chk("hs_ready", 32'(bus.cmd_ready), 32'h1);
    endtask

    initial begin
        logic [7:0] held;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_data  = 8'h00;
        bus.rsp_ready = 1'b0;
        aclr          = 1'b1;
        step();
        step();
        aclr = 1'b0;
        chk("rst_outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.rsp_err, bus.ir_in,
                                bus.v_cdr, bus.v_sdr, bus.udr, bus.tdi}), 32'b100_00_0000);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'h0);

        // WRITE 0x3C: prior DR1 is 0x00
        accept(2'b01, 8'h3C, 1'b1);
        run_body(2'b01, 8'h3C, 8'h00, 1'b0);
        chk("write_data_out", 32'(t_out), 32'h3C);
        handshake();

        // READ with data_in 0xA5
        t_in = 8'hA5;
        accept(2'b10, 8'h00, 1'b1);
        run_body(2'b10, 8'h00, 8'hA5, 1'b0);
        handshake();

        // BYPASS 0x81 -> 0x02, DR1 untouched
        accept(2'b00, 8'h81, 1'b1);
        run_body(2'b00, 8'h81, 8'h02, 1'b0);
        chk("bypass_data_out", 32'(t_out), 32'h3C);
        handshake();

        // Illegal op routes through bypass and flags the error
        accept(2'b11, 8'hFF, 1'b1);
        run_body(2'b00, 8'hFF, 8'hFE, 1'b1);
        handshake();
        chk("err_cleared_next_ok", 32'(t_out), 32'h3C);

        // Two queued commands: WRITE 0x11 then READ 0x5A with cmd_valid held
        t_in = 8'h5A;
        accept(2'b01, 8'h11, 1'b0);
        bus.cmd_op   = 2'b10;
        bus.cmd_data = 8'h00;
        run_body(2'b01, 8'h11, 8'h3C, 1'b0);
        held = bus.rsp_data;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("stall_valid", 32'(bus.rsp_valid), 32'h1);
            chk("stall_data", 32'(bus.rsp_data), 32'(held));
            chk("stall_ready", 32'(bus.cmd_ready), 32'h0);
        end
        handshake();
        chk("q2_not_yet", 32'(bus.ir_in), 32'h1);
        chk("q1_data_out", 32'(t_out), 32'h11);
        step();
        bus.cmd_valid = 1'b0;
        run_body(2'b10, 8'h00, 8'h5A, 1'b0);
        handshake();

        // Reset during shift cycle k=4 of WRITE 0x77
        accept(2'b01, 8'h77, 1'b1);
        step();
        for (int k = 0; k < 5; k++) step();
        chk("mid_shift", 32'(bus.v_sdr), 32'h1);
        aclr = 1'b1;
        step();
        aclr = 1'b0;
        chk("abort_outputs", 32'({bus.cmd_ready, bus.rsp_valid, bus.ir_in,
                                  bus.v_cdr, bus.v_sdr, bus.udr, bus.tdi}), 32'b10_00_0000);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("abort_no_rsp", 32'(bus.rsp_valid), 32'h0);
        end
        chk("abort_data_out", 32'(t_out), 32'h11);

        // Subsequent WRITE 0x55 completes normally
        accept(2'b01, 8'h55, 1'b1);
        run_body(2'b01, 8'h55, 8'h11, 1'b0);
        chk("final_data_out", 32'(t_out), 32'h55);
        handshake();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
